// File: rtl/hp_phase_clock_gen_pkg.sv
// hp_phase_clock_gen_pkg: shared mode encodings, FSM state enum and reset-default config
package hp_phase_clock_gen_pkg;

    localparam logic [1:0] MODE_RUN  = 2'b00;
    localparam logic [1:0] MODE_HALT = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;

    typedef enum logic [1:0] {S_HALT, S_RUN, S_STEP} state_t;

    localparam int DEF_DIV = 7;
    localparam int DEF_P1  = 5;
    localparam int DEF_P2  = 7;

endpackage

// File: rtl/hp_tstate_ring.sv
// hp_tstate_ring: one-hot T-state ring that rotates or resyncs on an advance strobe
//   osc_in   clock
//   cdiv_rst asynchronous active-high reset, ring returns to bit0
//   advance  rotate (or resync) on this edge
//   resync   when advancing, load one-hot SYNC_STATE instead of rotating
//   ring     one-hot T-state
module hp_tstate_ring #(
    parameter int N_TSTATE   = 4,
    parameter int SYNC_STATE = 2
) (
    input  logic                osc_in,
    input  logic                cdiv_rst,
    input  logic                advance,
    input  logic                resync,
    output logic [N_TSTATE-1:0] ring
);

    localparam logic [N_TSTATE-1:0] ONE     = {{(N_TSTATE-1){1'b0}}, 1'b1};
    localparam logic [N_TSTATE-1:0] SYNC_OH = ONE << SYNC_STATE;

    always_ff @(posedge osc_in or posedge cdiv_rst)
        if (cdiv_rst)
            ring <= ONE;
        else if (advance)
            ring <= resync ? SYNC_OH : {ring[N_TSTATE-2:0], ring[N_TSTATE-1]};

endmodule

// File: rtl/hp_phase_clock_gen.sv
// hp_phase_clock_gen: programmable two-phase clock generator with run/halt/step and T-state ring
//   osc_in      clock
//   cdiv_rst    asynchronous active-high reset
//   mode        00 run, 01 halt, 10 single-step, 11 halt
//   step        one-cycle pulse starting a single period in step mode
//   div_ratio   period minus one
//   phi1_pos    count that fires phi1
//   phi2_pos    count that fires phi2
//   resync_req  display resync, honoured only at a period boundary
//   phi1_n      active-low phi1 strobe
//   phi2_n      active-low phi2 strobe
//   tstate      one-hot T-state ring
//   cyc_cnt     completed periods, wrapping
//   busy        generator is not halted
//   cfg_err     sticky flag: last offered config was rejected
module hp_phase_clock_gen
    import hp_phase_clock_gen_pkg::*;
#(
    parameter int DIV_W      = 4,
    parameter int N_TSTATE   = 4,
    parameter int SYNC_STATE = 2,
    parameter int CYC_W      = 16
) (
    input  logic                osc_in,
    input  logic                cdiv_rst,
    input  logic [1:0]          mode,
    input  logic                step,
    input  logic [DIV_W-1:0]    div_ratio,
    input  logic [DIV_W-1:0]    phi1_pos,
    input  logic [DIV_W-1:0]    phi2_pos,
    input  logic                resync_req,
    output logic                phi1_n,
    output logic                phi2_n,
    output logic [N_TSTATE-1:0] tstate,
    output logic [CYC_W-1:0]    cyc_cnt,
    output logic                busy,
    output logic                cfg_err
);

    state_t           state, state_nxt;
    logic [DIV_W-1:0] cnt, div_act, p1_act, p2_act;
    logic             active, bnd, cfg_ok, cfg_load;

    assign active   = state != S_HALT;
    assign bnd      = active && cnt == div_act;
    assign busy     = active;
    assign cfg_ok   = div_ratio >= DIV_W'(2) && phi1_pos != phi2_pos &&
                      phi1_pos <= div_ratio && phi2_pos <= div_ratio;
    // The shadow is transparent while halted and otherwise only opens at the boundary,
    // so a running period never sees a config change.
    assign cfg_load = !active || bnd;

    always_comb begin
        state_nxt = state;
        case (state)
            S_HALT:  state_nxt = mode == MODE_RUN ? S_RUN :
                                 (mode == MODE_STEP && step) ? S_STEP : S_HALT;
            S_RUN:   state_nxt = (bnd && mode != MODE_RUN) ? S_HALT : S_RUN;
            S_STEP:  state_nxt = bnd ? S_HALT : S_STEP;
            default: state_nxt = S_HALT;
        endcase
    end

    always_ff @(posedge osc_in or posedge cdiv_rst)
        if (cdiv_rst) begin
            state   <= S_HALT;
            cnt     <= '0;
            div_act <= DIV_W'(DEF_DIV);
            p1_act  <= DIV_W'(DEF_P1);
            p2_act  <= DIV_W'(DEF_P2);
            phi1_n  <= 1'b1;
            phi2_n  <= 1'b1;
            cyc_cnt <= '0;
            cfg_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cfg_load ? '0 : cnt + DIV_W'(1);
            phi1_n  <= !(active && cnt == p1_act);
            phi2_n  <= !(active && cnt == p2_act);
            cyc_cnt <= cyc_cnt + CYC_W'(bnd);
            if (cfg_load) begin
                cfg_err <= !cfg_ok;
                if (cfg_ok) begin
                    div_act <= div_ratio;
                    p1_act  <= phi1_pos;
                    p2_act  <= phi2_pos;
                end
            end
        end

    hp_tstate_ring #(
        .N_TSTATE  (N_TSTATE),
        .SYNC_STATE(SYNC_STATE)
    ) u_ring (
        .osc_in  (osc_in),
        .cdiv_rst(cdiv_rst),
        .advance (bnd),
        .resync  (resync_req),
        .ring    (tstate)
    );

endmodule

// File: tb/tb_hp_phase_clock_gen.sv
// tb_hp_phase_clock_gen: directed scenarios plus random stimulus against a period-level reference model
module tb_hp_phase_clock_gen;

    localparam int DIV_W = 4, N_T = 4, SYNC = 2, CYC_W = 16;

    logic             osc_in = 1'b0;
    logic             cdiv_rst, step, resync_req;
    logic [1:0]       mode;
    logic [DIV_W-1:0] div_ratio, phi1_pos, phi2_pos;
    logic             phi1_n, phi2_n, busy, cfg_err;
    logic [N_T-1:0]   tstate;
    logic [CYC_W-1:0] cyc_cnt;

    hp_phase_clock_gen #(.DIV_W(DIV_W), .N_TSTATE(N_T), .SYNC_STATE(SYNC), .CYC_W(CYC_W)) dut (
        .osc_in(osc_in), .cdiv_rst(cdiv_rst), .mode(mode), .step(step),
        .div_ratio(div_ratio), .phi1_pos(phi1_pos), .phi2_pos(phi2_pos),
        .resync_req(resync_req), .phi1_n(phi1_n), .phi2_n(phi2_n), .tstate(tstate),
        .cyc_cnt(cyc_cnt), .busy(busy), .cfg_err(cfg_err)
    );

    always #5 osc_in = ~osc_in;

    // Reference model: "running" flag, position within period, active config,
    // T-state as an integer index, completed-period count.
    bit m_act, m_one;
    int m_pos, m_div, m_p1, m_p2, m_tidx, m_cyc, m_err, m_phi1, m_phi2;
    int n_checks = 0, n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_act = 0; m_one = 0; m_pos = 0;
        m_div = 7; m_p1 = 5; m_p2 = 7;
        m_tidx = 0; m_cyc = 0; m_err = 0; m_phi1 = 1; m_phi2 = 1;
    endtask

    task automatic model_step();
        bit bnd;
        bnd = m_act && m_pos == m_div;
        m_phi1 = (m_act && m_pos == m_p1) ? 0 : 1;
        m_phi2 = (m_act && m_pos == m_p2) ? 0 : 1;
        if (bnd) begin
            m_cyc = (m_cyc + 1) % (1 << CYC_W);
            m_tidx = resync_req ? SYNC : (m_tidx + 1) % N_T;
        end
        if (!m_act || bnd) begin
            if (int'(div_ratio) >= 2 && phi1_pos != phi2_pos &&
                phi1_pos <= div_ratio && phi2_pos <= div_ratio) begin
                m_div = div_ratio; m_p1 = phi1_pos; m_p2 = phi2_pos; m_err = 0;
            end else m_err = 1;
        end
        m_pos = (m_act && !bnd) ? m_pos + 1 : 0;
        if (!m_act) begin
            if (mode == 2'b00) begin m_act = 1; m_one = 0; end
            else if (mode == 2'b10 && step) begin m_act = 1; m_one = 1; end
        end else if (bnd && (m_one || mode != 2'b00)) m_act = 0;
    endtask

    task automatic compare_all();
        check("phi1_n", 32'(phi1_n), 32'(m_phi1));
        check("phi2_n", 32'(phi2_n), 32'(m_phi2));
        check("tstate", 32'(tstate), 32'(1) << m_tidx);
        check("cyc_cnt", 32'(cyc_cnt), 32'(m_cyc));
        check("busy", 32'(busy), 32'(m_act));
        check("cfg_err", 32'(cfg_err), 32'(m_err));
    endtask

    task automatic tick();
        @(posedge osc_in);
        if (!cdiv_rst) model_step();
        @(negedge osc_in);
        compare_all();
    endtask

    task automatic run_until(input int pos, output int n);
        n = 0;
        do begin tick(); n++; end while (m_pos != pos && n < 64);
        if (m_pos != pos) begin
            n_checks++;
            $display("FAIL wait_pos: reached %0d required %0d", m_pos, pos);
        end
    endtask

    task automatic set_cfg(input int d, input int a, input int b);
        div_ratio = DIV_W'(d); phi1_pos = DIV_W'(a); phi2_pos = DIV_W'(b);
    endtask

    // Asserts reset between edges and checks the outputs before any edge arrives.
    task automatic async_reset();
        #2 cdiv_rst = 1'b1;
        #1;
        check("rst_phi1_n", 32'(phi1_n), 32'd1);
        check("rst_phi2_n", 32'(phi2_n), 32'd1);
        check("rst_tstate", 32'(tstate), 32'b0001);
        check("rst_busy", 32'(busy), 32'd0);
        model_reset();
        compare_all();
        @(negedge osc_in);
        compare_all();
        cdiv_rst = 1'b0;
    endtask

    initial begin
        int n, c1, c2, cb, t1, t0, cyc0;
        cdiv_rst = 1'b1; mode = 2'b01; step = 0; resync_req = 0;
        set_cfg(7, 5, 7);
        model_reset();
        @(negedge osc_in);
        compare_all();
        @(negedge osc_in);
        cdiv_rst = 1'b0;

        // Default run: four periods of 8 cycles.
        mode = 2'b00;
        c1 = 0; c2 = 0; t1 = -10;
        for (int i = 0; i < 33; i++) begin
            tick();
            if (!phi1_n) begin c1++; t1 = i; end
            if (!phi2_n) begin c2++; check("phi2_after_phi1", 32'(i - t1), 32'd2); end
        end
        check("def_phi1_count", 32'(c1), 32'd4);
        check("def_phi2_count", 32'(c2), 32'd4);
        check("def_cyc4", 32'(cyc_cnt), 32'd4);
        check("def_tstate_wrap", 32'(tstate), 32'b0001);

        // Resync: mid-period pulse ignored, held across boundary loads T3.
        run_until(3, n);
        resync_req = 1; tick(); resync_req = 0;
        check("resync_mid_ignored", 32'(tstate), 32'b0001);
        run_until(7, n);
        resync_req = 1; tick(); resync_req = 0;
        check("resync_boundary", 32'(tstate), 32'b0100);

        // Mid-period ratio change takes effect only at the next period.
        run_until(2, n);
        set_cfg(3, 1, 3);
        run_until(0, n);
        check("cur_period_rest", 32'(n), 32'd6);
        run_until(0, n);
        check("new_period", 32'(n), 32'd4);
        check("new_cfg_err", 32'(cfg_err), 32'd0);

        // Invalid configs leave the active period unchanged.
        set_cfg(7, 5, 7);
        run_until(0, n);
        set_cfg(7, 5, 5);
        run_until(0, n);
        check("inv_same_pos_err", 32'(cfg_err), 32'd1);
        set_cfg(1, 0, 1);
        run_until(0, n);
        check("inv_period8", 32'(n), 32'd8);
        check("inv_small_div_err", 32'(cfg_err), 32'd1);
        set_cfg(7, 5, 7);
        run_until(0, n);
        check("valid_clears_err", 32'(cfg_err), 32'd0);

        // Single step with a redundant step pulse while busy.
        mode = 2'b01;
        run_until(0, n);
        repeat (3) tick();
        cyc0 = m_cyc; t0 = m_tidx;
        mode = 2'b10; step = 1;
        c1 = 0; c2 = 0; cb = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            step = (i == 2);
            cb += busy; c1 += !phi1_n; c2 += !phi2_n;
        end
        check("step_busy_cycles", 32'(cb), 32'd8);
        check("step_phi1_once", 32'(c1), 32'd1);
        check("step_phi2_once", 32'(c2), 32'd1);
        check("step_cyc_inc", 32'(cyc_cnt), 32'(cyc0 + 1));
        check("step_tstate_adv", 32'(tstate), 32'(1) << ((t0 + 1) % N_T));

        // Reset mid-period with a strobe in progress; config must revert to 7/5/7.
        set_cfg(5, 2, 4);
        mode = 2'b00;
        run_until(0, n);
        run_until(0, n);
        run_until(3, n);
        check("pre_rst_strobe", 32'(phi1_n), 32'd0);
        set_cfg(1, 0, 0);
        async_reset();
        run_until(0, n);
        run_until(0, n);
        check("rst_default_period", 32'(n), 32'd8);

        // Random stimulus against the model.
        set_cfg(7, 5, 7);
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom % 8;
            mode = r < 5 ? 2'b00 : r == 5 ? 2'b01 : r == 6 ? 2'b10 : 2'b11;
            step = ($urandom % 6) == 0;
            resync_req = ($urandom % 4) == 0;
            if ($urandom % 10 == 0)
                set_cfg($urandom % 16, $urandom % 16, $urandom % 16);
            if ($urandom % 400 == 0) async_reset();
            else tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
